// File: rtl/diferential_cfg_loader.sv
// -----------------------------------------------------------------------------
// diferential_cfg_loader
// Serial configuration loader for the muxpga fabric. A framed bit stream is
// shifted MSB-first into a shadow register. It is then committed to o_cfg_out
// in one step, so the fabric never sees a partially loaded configuration.
//
// Optional feature macro: DIFERENTIAL_CFG_PARITY_EN
//   When defined, each frame carries one trailing even-parity bit. A frame that
//   fails the parity check sets o_cfg_error and is not committed.
//   When undefined, frames are exactly N bits and o_cfg_error is tied to 0.
//
// Ports:
//   i_clk         fabric clock, rising edge
//   i_rst_n       asynchronous active-low reset
//   i_cfg_start   one-cycle pulse; starts a frame and aborts any frame in flight
//   i_cfg_valid   qualifies i_cfg_data in the current cycle
//   i_cfg_data    serial configuration bit
//   o_cfg_out     committed configuration, N = ROWS*COLS*CFG_BITS bits;
//                 cell (r,c) = o_cfg_out[(r*COLS+c)*CFG_BITS +: CFG_BITS]
//   o_cfg_loaded  high once at least one frame has committed since reset
//   o_cfg_busy    high while a frame is in progress
//   o_cfg_error   last frame failed its parity check; sticky until next start
// -----------------------------------------------------------------------------
module diferential_cfg_loader #(
  parameter int unsigned ROWS     = 3,
  parameter int unsigned COLS     = 3,
  parameter int unsigned CFG_BITS = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_cfg_start,
  input  logic                          i_cfg_valid,
  input  logic                          i_cfg_data,
  output logic [ROWS*COLS*CFG_BITS-1:0] o_cfg_out,
  output logic                          o_cfg_loaded,
  output logic                          o_cfg_busy,
  output logic                          o_cfg_error
);

  localparam int unsigned N  = ROWS * COLS * CFG_BITS;
  localparam int unsigned CW = $clog2(N + 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;
`ifdef DIFERENTIAL_CFG_PARITY_EN
  localparam logic [1:0] ST_PARITY = 2'd3;
`endif

  logic [1:0]    r_state,  w_state_d;
  logic [N-1:0]  r_shadow, w_shadow_d;
  logic [N-1:0]  r_out,    w_out_d;
  logic [CW-1:0] r_cnt,    w_cnt_d;
  logic          r_loaded, w_loaded_d;
  logic          w_last_bit;

`ifdef DIFERENTIAL_CFG_PARITY_EN
  logic          r_error,  w_error_d;
`endif

  // The bit accepted while the counter is N-1 completes the payload.
  assign w_last_bit = (r_cnt == CW'(N - 1));

  always_comb begin
    w_state_d  = r_state;
    w_shadow_d = r_shadow;
    w_out_d    = r_out;
    w_cnt_d    = r_cnt;
    w_loaded_d = r_loaded;
`ifdef DIFERENTIAL_CFG_PARITY_EN
    w_error_d  = r_error;
`endif

    if (i_cfg_start) begin
      // Start wins in every state; the data bit in this cycle is dropped.
      w_state_d  = ST_SHIFT;
      w_shadow_d = '0;
      w_cnt_d    = '0;
`ifdef DIFERENTIAL_CFG_PARITY_EN
      w_error_d  = 1'b0;
`endif
    end else begin
      case (r_state)
        ST_SHIFT: begin
          if (i_cfg_valid) begin
            w_shadow_d = {r_shadow[N-2:0], i_cfg_data};
            w_cnt_d    = r_cnt + CW'(1);
            if (w_last_bit) begin
`ifdef DIFERENTIAL_CFG_PARITY_EN
              w_state_d = ST_PARITY;
`else
              w_state_d = ST_COMMIT;
`endif
            end
          end
        end
`ifdef DIFERENTIAL_CFG_PARITY_EN
        ST_PARITY: begin
          if (i_cfg_valid) begin
            // Even parity over payload plus parity bit.
            if ((^r_shadow) ^ i_cfg_data) begin
              w_error_d = 1'b1;
              w_state_d = ST_IDLE;
            end else begin
              w_state_d = ST_COMMIT;
            end
          end
        end
`endif
        ST_COMMIT: begin
          w_out_d    = r_shadow;
          w_loaded_d = 1'b1;
          w_state_d  = ST_IDLE;
        end
        default: begin
          // Idle ignores cfg_valid entirely.
          w_state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= ST_IDLE;
      r_shadow <= '0;
      r_out    <= '0;
      r_cnt    <= '0;
      r_loaded <= 1'b0;
`ifdef DIFERENTIAL_CFG_PARITY_EN
      r_error  <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_d;
      r_shadow <= w_shadow_d;
      r_out    <= w_out_d;
      r_cnt    <= w_cnt_d;
      r_loaded <= w_loaded_d;
`ifdef DIFERENTIAL_CFG_PARITY_EN
      r_error  <= w_error_d;
`endif
    end
  end

  assign o_cfg_out    = r_out;
  assign o_cfg_loaded = r_loaded;
  assign o_cfg_busy   = (r_state != ST_IDLE);
`ifdef DIFERENTIAL_CFG_PARITY_EN
  assign o_cfg_error  = r_error;
`else
  assign o_cfg_error  = 1'b0;
`endif

endmodule

// File: tb/tb_diferential_cfg_loader.sv
// -----------------------------------------------------------------------------
// tb_diferential_cfg_loader
// Directed bench for diferential_cfg_loader at default size (36-bit frames).
// Stimulus pushes the expected end-of-frame result into a queue. A monitor pops
// that queue whenever o_cfg_busy falls and compares the outputs against it.
// -----------------------------------------------------------------------------
module tb_diferential_cfg_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_start = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_data = 1'b0;
  logic [35:0] cfg_out;
  logic        cfg_loaded;
  logic        cfg_busy;
  logic        cfg_error;

  diferential_cfg_loader #(
    .ROWS     (3),
    .COLS     (3),
    .CFG_BITS (4)
  ) u_dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_cfg_start  (cfg_start),
    .i_cfg_valid  (cfg_valid),
    .i_cfg_data   (cfg_data),
    .o_cfg_out    (cfg_out),
    .o_cfg_loaded (cfg_loaded),
    .o_cfg_busy   (cfg_busy),
    .o_cfg_error  (cfg_error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [35:0] out;
    logic        loaded;
    logic        err;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [35:0] model_out = '0;
  logic        model_loaded = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Apply inputs now, then advance to 1 time unit past the next rising edge.
  task automatic cyc(input logic s, input logic v, input logic d);
    cfg_start = s;
    cfg_valid = v;
    cfg_data  = d;
    @(posedge clk);
    #1;
  endtask

  // Send a frame of nbits payload bits (a full frame is 36). The start cycle
  // carries the complement of the first bit, which must be dropped.
  task automatic send(input logic [35:0] val, input int nbits, input bit stall,
                      input bit par_ok);
    logic [35:0] old;
    old = cfg_out;
    if (nbits == 36) begin
      if (par_ok) begin
        sb_q.push_back({val, 1'b1, 1'b0});
        model_out    = val;
        model_loaded = 1'b1;
      end else begin
        sb_q.push_back({model_out, model_loaded, 1'b1});
      end
    end
    cyc(1'b1, 1'b1, ~val[35]);
    for (int i = 0; i < nbits; i++) begin
      cyc(1'b0, 1'b1, val[35 - i]);
      if (stall && (i % 5 == 4) && (i != nbits - 1)) begin
        repeat (3) cyc(1'b0, 1'b0, 1'($urandom));
        chk("hold_during_stall", 64'(cfg_out), 64'(old));
      end
    end
    if (nbits != 36) begin
      chk("hold_partial_frame", 64'(cfg_out), 64'(old));
      chk("busy_partial_frame", 64'(cfg_busy), 64'd1);
      return;
    end
`ifdef DIFERENTIAL_CFG_PARITY_EN
    cyc(1'b0, 1'b1, (^val) ^ ~par_ok);
`endif
    if (par_ok) begin
      chk("out_before_commit", 64'(cfg_out), 64'(old));
      chk("busy_before_commit", 64'(cfg_busy), 64'd1);
      cyc(1'b0, 1'b0, 1'b0);
      chk("out_after_commit", 64'(cfg_out), 64'(val));
    end else begin
      chk("error_after_bad_parity", 64'(cfg_error), 64'd1);
      chk("out_kept_bad_parity", 64'(cfg_out), 64'(old));
      cyc(1'b0, 1'b0, 1'b0);
    end
  endtask

  // Monitor: each end of frame (busy falling) is one scoreboard transaction.
  initial begin : monitor
    logic prev_busy;
    exp_t e;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_busy = 1'b0;
      end else begin
        if (prev_busy && !cfg_busy) begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame_end: got out %0h with empty queue", cfg_out);
          end else begin
            e = sb_q.pop_front();
            chk("sb_cfg_out", 64'(cfg_out), 64'(e.out));
            chk("sb_cfg_loaded", 64'(cfg_loaded), 64'(e.loaded));
            chk("sb_cfg_error", 64'(cfg_error), 64'(e.err));
          end
        end
        prev_busy = cfg_busy;
      end
    end
  end

  initial begin : timeout
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [35:0] held;
    int          waited;

    // Reset values, before any clock edge.
    #2;
    chk("rst_out", 64'(cfg_out), 64'd0);
    chk("rst_loaded", 64'(cfg_loaded), 64'd0);
    chk("rst_busy", 64'(cfg_busy), 64'd0);
    chk("rst_error", 64'(cfg_error), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);

    // Basic load and cell mapping.
    send(36'h123456789, 36, 1'b0, 1'b1);
    chk("cell_0_0", 64'(cfg_out[3:0]), 64'h9);
    chk("cell_2_2", 64'(cfg_out[35:32]), 64'h1);
    chk("loaded_after_basic", 64'(cfg_loaded), 64'd1);
    chk("busy_after_basic", 64'(cfg_busy), 64'd0);

    // Asynchronous reset in the middle of a frame.
    send(36'hFFFFFFFFF, 10, 1'b0, 1'b1);
    rst_n = 1'b0;
    cfg_valid = 1'b0;
    #1;
    chk("midrst_out", 64'(cfg_out), 64'd0);
    chk("midrst_loaded", 64'(cfg_loaded), 64'd0);
    chk("midrst_busy", 64'(cfg_busy), 64'd0);
    chk("midrst_error", 64'(cfg_error), 64'd0);
    model_out    = '0;
    model_loaded = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);

    // Stalled frame; output must stay at zero until the commit edge.
    send(36'h123456789, 36, 1'b1, 1'b1);

    // Idle noise must not disturb anything.
    held = cfg_out;
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 1'(i), 1'($urandom));
      chk("idle_busy", 64'(cfg_busy), 64'd0);
    end
    chk("idle_out", 64'(cfg_out), 64'(held));

    // Abort: a 20-bit frame is cut short by the next start.
    send(36'hFFFFFFFFF, 36, 1'b0, 1'b1);
    send(36'h5A5A5A5A5, 20, 1'b0, 1'b1);
    send(36'h000000ABC, 36, 1'b0, 1'b1);

`ifdef DIFERENTIAL_CFG_PARITY_EN
    // 36'h123456789 has 15 ones, so the passing parity bit is 1.
    send(36'h123456789, 36, 1'b0, 1'b1);
    chk("par_pass_error", 64'(cfg_error), 64'd0);
    send(36'h123456789, 36, 1'b0, 1'b0);
    chk("par_fail_loaded", 64'(cfg_loaded), 64'd1);
    cyc(1'b1, 1'b0, 1'b0);
    chk("start_clears_error", 64'(cfg_error), 64'd0);
    chk("start_sets_busy", 64'(cfg_busy), 64'd1);
    send(36'h000000ABC, 36, 1'b0, 1'b1);
`endif

    // Let the monitor drain the queue, within a bounded number of cycles.
    waited = 0;
    while (sb_q.size() != 0 && waited < 20) begin
      cyc(1'b0, 1'b0, 1'b0);
      waited++;
    end
    repeat (2) cyc(1'b0, 1'b0, 1'b0);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
